// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM responder slice.
package ram_pkg;

   // Request lifecycle: waiting for a request, counting latency, completion pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } ram_state_t;

   localparam int unsigned RAM_LAT_MAX = 15;
   localparam int unsigned RAM_STAT_W  = 16;
   localparam int unsigned RAM_CNT_W   = 4;

endpackage

// File: rtl/component_down_counter.sv
// Loadable down-counter with zero flag; used to time the memory access latency.
module component_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_dec,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_count;
   logic         w_zero;

   assign w_zero = (r_count == '0);
   assign o_zero = w_zero;

   // Load has priority; decrement stops at zero
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && !w_zero) begin
         r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: single-word read/write with modelled latency and a
// one-cycle done pulse. Optional read/write statistics counters are enabled by
// defining RAM_RESPONDER_STATS_EN.
module ram_responder
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LATENCY    = 4   // legal range 1..RAM_LAT_MAX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  RAM_we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      data_out,
   output logic                  done,
   output logic                  busy
`ifdef RAM_RESPONDER_STATS_EN
   ,
   output logic [RAM_STAT_W-1:0] rd_count,
   output logic [RAM_STAT_W-1:0] wr_count
`endif
);

   localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [RAM_CNT_W-1:0] LAT_LOAD = RAM_CNT_W'(LATENCY - 1);

   ram_state_t r_state, w_state_next;

   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]      r_data;
   logic [WIDTH-1:0]      r_data_out;
   logic [WIDTH-1:0]      r_mem [DEPTH];

   logic w_accept;
   logic w_access;
   logic w_zero;

   // IDLE and DONE both accept a new request; WAIT ignores req
   assign w_accept = req && ((r_state == IDLE) || (r_state == DONE));
   assign w_access = (r_state == WAIT) && w_zero;

   assign done     = (r_state == DONE);
   assign busy     = (r_state == WAIT);
   assign data_out = r_data_out;

   component_down_counter #(
      .W (RAM_CNT_W)
   ) u_lat_cnt (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_accept),
      .i_dec      (r_state == WAIT),
      .i_load_val (LAT_LOAD),
      .o_zero     (w_zero)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (req) w_state_next = WAIT;
         WAIT:    if (w_zero) w_state_next = DONE;
         DONE:    w_state_next = req ? WAIT : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Capture request fields on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_we   <= RAM_we;
         r_addr <= addr;
         r_data <= data_in;
      end
   end

   // Memory array is deliberately unreset; reset leaves WAIT so a pending write is dropped
   always_ff @(posedge clk) begin
      if (w_access && r_we) begin
         r_mem[r_addr] <= r_data;
      end
   end

   // Read data register holds the last completed read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out <= '0;
      end else if (w_access && !r_we) begin
         r_data_out <= r_mem[r_addr];
      end
   end

`ifdef RAM_RESPONDER_STATS_EN
   logic [RAM_STAT_W-1:0] r_rd_count;
   logic [RAM_STAT_W-1:0] r_wr_count;

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;

   // Saturating completion counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else if (w_access) begin
         if (!r_we && (r_rd_count != '1)) r_rd_count <= r_rd_count + 1'b1;
         if (r_we && (r_wr_count != '1))  r_wr_count <= r_wr_count + 1'b1;
      end
   end
`endif

endmodule
